// File: rtl/id_stage_s_pkg.sv
// Shared constants for the decode stage: RV32I opcodes, ALU operation codes,
// the ID/EX payload record and small decode helpers.
package id_stage_s_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic          valid;
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic [31:0]   rs1_data;
    logic [31:0]   rs2_data;
    logic [31:0]   imm;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;
    logic [2:0]    funct3;
    alu_op_e       alu_op;
    logic          alu_src;
    logic          mem_read;
    logic          mem_write;
    logic          reg_write;
    logic          branch;
    logic          jump;
    logic          illegal;
  } idex_t;

  function automatic idex_t bubble(input logic [31:0] nop);
    idex_t b;
    b       = '0;
    b.instr = nop;
    return b;
  endfunction

  // The subtract select only exists for register-register ops; addi has no SUB form.
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic b30,
                                         input logic is_reg);
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      3'b000: op = (is_reg && b30) ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = b30 ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic rs1_used(input logic [6:0] opc);
    return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
  endfunction

  function automatic logic rs2_used(input logic [6:0] opc);
    return (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/id_stage_s_if.sv
// Bundle of fetch, writeback, hazard and ID/EX signals around the decode stage.
interface id_stage_s_if;
  import id_stage_s_pkg::*;

  logic        is_flush;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;

  logic        stall_req;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  alu_op_e     alu_op;
  logic        alu_src;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        branch;
  logic        jump;
  logic        illegal;

  modport slave (
    input  is_flush, if_valid, if_pc, if_instr, wb_we, wb_rd, wb_data,
           ex_mem_read, ex_rd,
    output stall_req, id_valid, id_pc, id_instr, rs1_data, rs2_data, imm,
           rs1, rs2, rd, funct3, alu_op, alu_src, mem_read, mem_write,
           reg_write, branch, jump, illegal
  );

  modport master (
    output is_flush, if_valid, if_pc, if_instr, wb_we, wb_rd, wb_data,
           ex_mem_read, ex_rd,
    input  stall_req, id_valid, id_pc, id_instr, rs1_data, rs2_data, imm,
           rs1, rs2, rd, funct3, alu_op, alu_src, mem_read, mem_write,
           reg_write, branch, jump, illegal
  );

endinterface

// File: rtl/id_stage_s_regfile.sv
// 32x32 register file: two combinational read ports, one clocked write port,
// x0 hardwired to zero and same-cycle write data forwarded to the readers.
module regfile_s (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0][31:0] regs_q;
  logic [31:0][31:0] regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we && waddr != 5'd0) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  // Write-through: a reader sees the value being written this cycle.
  always_comb begin
    rdata1 = regs_q[raddr1];
    rdata2 = regs_q[raddr2];
    if (we && waddr == raddr1) rdata1 = wdata;
    if (we && waddr == raddr2) rdata2 = wdata;
    if (raddr1 == 5'd0) rdata1 = '0;
    if (raddr2 == 5'd0) rdata2 = '0;
  end

endmodule

// File: rtl/id_stage_s.sv
// RV32I decode stage: register read, immediate generation, control decode,
// load-use stall detection and the ID/EX pipeline register.
module id_stage_s
  import id_stage_s_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  id_stage_s_if.slave   bus
);

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        hazard;
  logic        stall;
  idex_t       dec;
  idex_t       idex_d;
  idex_t       idex_q;

  assign instr   = bus.if_instr;
  assign opcode  = instr[6:0];
  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];

  regfile_s u_regfile (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (rs1_idx),
    .raddr2 (rs2_idx),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2),
    .we     (bus.wb_we),
    .waddr  (bus.wb_rd),
    .wdata  (bus.wb_data)
  );

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec          = '0;
    dec.valid    = 1'b1;
    dec.pc       = bus.if_pc;
    dec.instr    = instr;
    dec.rs1      = rs1_idx;
    dec.rs2      = rs2_idx;
    dec.rd       = instr[11:7];
    dec.funct3   = instr[14:12];
    dec.rs1_data = rf_rdata1;
    dec.rs2_data = rf_rdata2;
    dec.alu_op   = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = alu_decode(instr[14:12], instr[30], 1'b1);
      end
      OPC_OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = imm_i;
        dec.alu_op    = alu_decode(instr[14:12], instr[30], 1'b0);
      end
      OPC_LOAD: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.mem_read  = 1'b1;
        dec.imm       = imm_i;
      end
      OPC_STORE: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.imm       = imm_s;
      end
      OPC_BRANCH: begin
        dec.branch    = 1'b1;
        dec.imm       = imm_b;
        dec.alu_op    = ALU_SUB;
      end
      OPC_JAL: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.jump      = 1'b1;
        dec.imm       = imm_j;
      end
      OPC_JALR: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.jump      = 1'b1;
        dec.imm       = imm_i;
      end
      OPC_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = imm_u;
        dec.alu_op    = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = imm_u;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Load-use hazard only counts against sources the opcode actually reads.
  always_comb begin
    hazard = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
             ((rs1_used(opcode) && bus.ex_rd == rs1_idx) ||
              (rs2_used(opcode) && bus.ex_rd == rs2_idx));
    stall  = reset && bus.if_valid && hazard && !bus.is_flush;
  end

  assign bus.stall_req = stall;

  always_comb begin
    idex_d = dec;
    if (bus.is_flush || stall || !bus.if_valid) idex_d = bubble(NOP_INSTR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idex_q <= bubble(NOP_INSTR);
    else        idex_q <= idex_d;
  end

  assign bus.id_valid  = idex_q.valid;
  assign bus.id_pc     = idex_q.pc;
  assign bus.id_instr  = idex_q.instr;
  assign bus.rs1_data  = idex_q.rs1_data;
  assign bus.rs2_data  = idex_q.rs2_data;
  assign bus.imm       = idex_q.imm;
  assign bus.rs1       = idex_q.rs1;
  assign bus.rs2       = idex_q.rs2;
  assign bus.rd        = idex_q.rd;
  assign bus.funct3    = idex_q.funct3;
  assign bus.alu_op    = idex_q.alu_op;
  assign bus.alu_src   = idex_q.alu_src;
  assign bus.mem_read  = idex_q.mem_read;
  assign bus.mem_write = idex_q.mem_write;
  assign bus.reg_write = idex_q.reg_write;
  assign bus.branch    = idex_q.branch;
  assign bus.jump      = idex_q.jump;
  assign bus.illegal   = idex_q.illegal;

endmodule

// File: tb/tb_id_stage_s.sv
// Self-checking bench for id_stage_s: directed scenarios followed by random
// instruction streams compared against a behavioural decode/regfile model.
module tb_id_stage_s;
  import id_stage_s_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;

  id_stage_s_if bus ();

  id_stage_s #(.NOP_INSTR(32'h0000_0013)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc, instr, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        alu_src, mem_read, mem_write, reg_write, branch, jump, illegal;
  } exp_t;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] model_regs [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t bubble_exp();
    exp_t e;
    e = '{valid: 1'b0, pc: 32'd0, instr: 32'h0000_0013, rs1_data: 32'd0,
          rs2_data: 32'd0, imm: 32'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
          funct3: 3'd0, alu_op: 4'd0, alu_src: 1'b0, mem_read: 1'b0,
          mem_write: 1'b0, reg_write: 1'b0, branch: 1'b0, jump: 1'b0,
          illegal: 1'b0};
    return e;
  endfunction

  // Register read as seen by decode this cycle, including a same-cycle write.
  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] wrd, input logic [31:0] wdata);
    if (idx == 5'd0) return 32'd0;
    if (we && wrd == idx) return wdata;
    return model_regs[idx];
  endfunction

  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic we, input logic [4:0] wrd,
                                        input logic [31:0] wdata);
    exp_t e;
    int   sgn;
    int   f3;
    e = bubble_exp();
    e.valid = 1'b1; e.pc = pc; e.instr = ins;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.funct3 = ins[14:12];
    e.rs1_data = model_read(ins[19:15], we, wrd, wdata);
    e.rs2_data = model_read(ins[24:20], we, wrd, wdata);
    sgn = ins[31] ? -1 : 0;
    f3  = int'(ins[14:12]);
    e.alu_op = ALU_ADD;
    case (ins[6:0])
      7'b0110011, 7'b0010011: begin
        e.reg_write = 1'b1;
        e.alu_src   = (ins[6:0] == 7'b0010011);
        if (e.alu_src) e.imm = sgn * 2048 + int'(ins[30:20]);
        case (f3)
          0: e.alu_op = (!e.alu_src && ins[30]) ? ALU_SUB : ALU_ADD;
          1: e.alu_op = ALU_SLL;
          2: e.alu_op = ALU_SLT;
          3: e.alu_op = ALU_SLTU;
          4: e.alu_op = ALU_XOR;
          5: e.alu_op = ins[30] ? ALU_SRA : ALU_SRL;
          6: e.alu_op = ALU_OR;
          default: e.alu_op = ALU_AND;
        endcase
      end
      7'b0000011: begin
        e.reg_write = 1'b1; e.alu_src = 1'b1; e.mem_read = 1'b1;
        e.imm = sgn * 2048 + int'(ins[30:20]);
      end
      7'b0100011: begin
        e.alu_src = 1'b1; e.mem_write = 1'b1;
        e.imm = sgn * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:7]);
      end
      7'b1100011: begin
        e.branch = 1'b1; e.alu_op = ALU_SUB;
        e.imm = sgn * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      end
      7'b1101111: begin
        e.reg_write = 1'b1; e.alu_src = 1'b1; e.jump = 1'b1;
        e.imm = sgn * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      end
      7'b1100111: begin
        e.reg_write = 1'b1; e.alu_src = 1'b1; e.jump = 1'b1;
        e.imm = sgn * 2048 + int'(ins[30:20]);
      end
      7'b0110111, 7'b0010111: begin
        e.reg_write = 1'b1; e.alu_src = 1'b1;
        e.imm = ins & 32'hFFFF_F000;
        if (ins[6:0] == 7'b0110111) e.alu_op = ALU_PASS_B;
      end
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic model_stall(input logic [31:0] ins, input logic valid,
                                       input logic flush, input logic exmr,
                                       input logic [4:0] exrd);
    logic [6:0] opc;
    logic       use1, use2;
    opc  = ins[6:0];
    use1 = !(opc == 7'b0110111 || opc == 7'b0010111 || opc == 7'b1101111);
    use2 = (opc == 7'b0110011 || opc == 7'b0100011 || opc == 7'b1100011);
    return valid && exmr && exrd != 5'd0 && !flush &&
           ((use1 && exrd == ins[19:15]) || (use2 && exrd == ins[24:20]));
  endfunction

  task automatic check_output(input string tag, input exp_t e);
    check({tag, ".id_valid"},  32'(bus.id_valid),  32'(e.valid));
    check({tag, ".id_pc"},     bus.id_pc,          e.pc);
    check({tag, ".id_instr"},  bus.id_instr,       e.instr);
    check({tag, ".rs1_data"},  bus.rs1_data,       e.rs1_data);
    check({tag, ".rs2_data"},  bus.rs2_data,       e.rs2_data);
    check({tag, ".imm"},       bus.imm,            e.imm);
    check({tag, ".rs1"},       32'(bus.rs1),       32'(e.rs1));
    check({tag, ".rs2"},       32'(bus.rs2),       32'(e.rs2));
    check({tag, ".rd"},        32'(bus.rd),        32'(e.rd));
    check({tag, ".funct3"},    32'(bus.funct3),    32'(e.funct3));
    check({tag, ".alu_op"},    32'(bus.alu_op),    32'(e.alu_op));
    check({tag, ".alu_src"},   32'(bus.alu_src),   32'(e.alu_src));
    check({tag, ".mem_read"},  32'(bus.mem_read),  32'(e.mem_read));
    check({tag, ".mem_write"}, 32'(bus.mem_write), 32'(e.mem_write));
    check({tag, ".reg_write"}, 32'(bus.reg_write), 32'(e.reg_write));
    check({tag, ".branch"},    32'(bus.branch),    32'(e.branch));
    check({tag, ".jump"},      32'(bus.jump),      32'(e.jump));
    check({tag, ".illegal"},   32'(bus.illegal),   32'(e.illegal));
  endtask

  // One pipeline cycle: drive, check the stall request, clock, check ID/EX.
  task automatic apply_stimulus(input string tag, input logic valid, input logic [31:0] pc,
                                input logic [31:0] ins, input logic flush,
                                input logic we, input logic [4:0] wrd, input logic [31:0] wdata,
                                input logic exmr, input logic [4:0] exrd);
    exp_t e;
    logic st;
    bus.if_valid = valid; bus.if_pc = pc; bus.if_instr = ins; bus.is_flush = flush;
    bus.wb_we = we; bus.wb_rd = wrd; bus.wb_data = wdata;
    bus.ex_mem_read = exmr; bus.ex_rd = exrd;
    #1;
    st = model_stall(ins, valid, flush, exmr, exrd);
    check({tag, ".stall_req"}, 32'(bus.stall_req), 32'(st));
    if (!valid || flush || st) e = bubble_exp();
    else                       e = model_decode(ins, pc, we, wrd, wdata);
    @(posedge clk);
    if (we && wrd != 5'd0) model_regs[wrd] = wdata;
    #1;
    check_output(tag, e);
  endtask

  logic [6:0]  opc_table [10];
  logic [31:0] rnd_instr;

  initial begin
    opc_table = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;

    // Reset: hazard-shaped inputs must not raise stall, outputs are bubble.
    bus.if_valid = 1'b1; bus.if_pc = 32'h100; bus.if_instr = 32'h0011_02B3;
    bus.is_flush = 1'b0; bus.wb_we = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd2;
    #22;
    check("reset.stall_req", 32'(bus.stall_req), 32'd0);
    check_output("reset", bubble_exp());
    @(negedge clk);
    reset = 1'b1;

    apply_stimulus("addi", 1'b1, 32'h0000_0100, 32'h0050_0093, 1'b0,
                   1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    apply_stimulus("wthru", 1'b1, 32'h0000_0104, 32'h0001_8233, 1'b0,
                   1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0);
    check("wthru.direct", bus.rs1_data, 32'hDEAD_BEEF);
    apply_stimulus("loaduse", 1'b1, 32'h0000_0108, 32'h0011_02B3, 1'b0,
                   1'b0, 5'd0, 32'd0, 1'b1, 5'd2);
    check("loaduse.direct", 32'(bus.id_valid), 32'd0);
    apply_stimulus("exrd0", 1'b1, 32'h0000_0108, 32'h0011_02B3, 1'b0,
                   1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    apply_stimulus("flush", 1'b1, 32'h0000_010C, 32'h0011_02B3, 1'b1,
                   1'b0, 5'd0, 32'd0, 1'b1, 5'd2);
    check("flush.direct", bus.id_instr, 32'h0000_0013);
    apply_stimulus("beq", 1'b1, 32'h0000_0110, 32'hFE20_8CE3, 1'b0,
                   1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("beq.direct", bus.imm, 32'hFFFF_FFF8);
    apply_stimulus("illegal", 1'b1, 32'h0000_0114, 32'h0000_007F, 1'b0,
                   1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

    for (int n = 0; n < 300; n++) begin
      rnd_instr        = $urandom;
      rnd_instr[6:0]   = opc_table[$urandom_range(0, 9)];
      rnd_instr[19:15] = 5'($urandom_range(0, 7));
      rnd_instr[24:20] = 5'($urandom_range(0, 7));
      apply_stimulus("rand", $urandom_range(0, 99) < 85, $urandom, rnd_instr,
                     $urandom_range(0, 99) < 10, 1'($urandom), 5'($urandom_range(0, 7)),
                     $urandom, 1'($urandom), 5'($urandom_range(0, 7)));
    end

    // Mid-stream reset: x1 holds data, then reset clears outputs and registers.
    apply_stimulus("wr_x1", 1'b0, 32'd0, 32'd0, 1'b0,
                   1'b1, 5'd1, 32'h0000_1234, 1'b0, 5'd0);
    apply_stimulus("rd_x1", 1'b1, 32'h0000_0200, 32'h0000_8233, 1'b0,
                   1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    bus.if_instr = 32'h0000_8233; bus.if_valid = 1'b1;
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd1;
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    check("midreset.stall_req", 32'(bus.stall_req), 32'd0);
    check_output("midreset", bubble_exp());
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus("post_x1", 1'b1, 32'h0000_0300, 32'h0000_8233, 1'b0,
                   1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check("post_x1.direct", bus.rs1_data, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
